// File: rtl/tx_arbiter.sv
// Shares one UART transmitter between a metadata requester and a sample-burst requester.
// Metadata wins at byte boundaries and can lock the UART across a multi-byte message.
module tx_arbiter #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    meta_req,
  input  logic [7:0]              meta_byte,
  input  logic                    meta_last,
  output logic                    meta_ack,
  input  logic                    data_valid,
  input  logic [SAMPLE_WIDTH-1:0] data_byte,
  output logic                    data_ack,
  input  logic                    start_readout,
  input  logic [15:0]             read_count,
  output logic                    readout_done,
  input  logic                    tx_busy,
  output logic                    trans_en,
  output logic [7:0]              tx_data,
  output logic                    grant_meta,
  output logic                    busy_err
);

  localparam int CntW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_e;

  state_e          state_q, state_d;
  logic            ownerMeta_q, ownerMeta_d;
  logic            lastMeta_q, lastMeta_d;
  logic            lock_q, lock_d;
  logic [7:0]      txData_q, txData_d;
  logic [CntW-1:0] timer_q, timer_d;
  logic [15:0]     remaining_q, remaining_d;
  logic            transEn_q, transEn_d;
  logic            metaAck_q, metaAck_d;
  logic            dataAck_q, dataAck_d;
  logic            readoutDone_q, readoutDone_d;
  logic            grantMeta_q, grantMeta_d;
  logic            busyErr_q, busyErr_d;
  logic            xferDone;
  logic            readoutActive;

  assign readoutActive = (remaining_q != 16'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      ownerMeta_q   <= 1'b0;
      lastMeta_q    <= 1'b0;
      lock_q        <= 1'b0;
      txData_q      <= 8'd0;
      timer_q       <= '0;
      remaining_q   <= 16'd0;
      transEn_q     <= 1'b0;
      metaAck_q     <= 1'b0;
      dataAck_q     <= 1'b0;
      readoutDone_q <= 1'b0;
      grantMeta_q   <= 1'b0;
      busyErr_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ownerMeta_q   <= ownerMeta_d;
      lastMeta_q    <= lastMeta_d;
      lock_q        <= lock_d;
      txData_q      <= txData_d;
      timer_q       <= timer_d;
      remaining_q   <= remaining_d;
      transEn_q     <= transEn_d;
      metaAck_q     <= metaAck_d;
      dataAck_q     <= dataAck_d;
      readoutDone_q <= readoutDone_d;
      grantMeta_q   <= grantMeta_d;
      busyErr_q     <= busyErr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ownerMeta_d   = ownerMeta_q;
    lastMeta_d    = lastMeta_q;
    lock_d        = lock_q;
    txData_d      = txData_q;
    timer_d       = timer_q;
    remaining_d   = remaining_q;
    transEn_d     = 1'b0;
    metaAck_d     = 1'b0;
    dataAck_d     = 1'b0;
    readoutDone_d = 1'b0;
    busyErr_d     = busyErr_q;
    xferDone      = 1'b0;

    case (state_q)
      // Requesters still show their request during the ack cycle, so no selection then.
      IDLE: begin
        if (!tx_busy && !metaAck_q && !dataAck_q) begin
          if (meta_req) begin
            ownerMeta_d = 1'b1;
            lastMeta_d  = meta_last;
            txData_d    = meta_byte;
            state_d     = ISSUE;
          end else if (!lock_q && readoutActive && data_valid) begin
            ownerMeta_d = 1'b0;
            txData_d    = 8'(data_byte);
            state_d     = ISSUE;
          end
        end
      end
      ISSUE: begin
        transEn_d = 1'b1;
        timer_d   = '0;
        state_d   = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (timer_q == CntLast) begin
          busyErr_d = 1'b1;
          xferDone  = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) xferDone = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (xferDone) begin
      state_d = IDLE;
      if (ownerMeta_q) begin
        metaAck_d = 1'b1;
        lock_d    = !lastMeta_q;
      end else begin
        dataAck_d = 1'b1;
        if (remaining_q != 16'd0) begin
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) readoutDone_d = 1'b1;
        end
      end
    end

    // A zero-length burst completes immediately; a restart during a burst is dropped.
    if (start_readout && !readoutActive) begin
      if (read_count == 16'd0) readoutDone_d = 1'b1;
      else                     remaining_d   = read_count;
    end

    grantMeta_d = (ownerMeta_d && (state_d != IDLE)) || lock_d;
  end

  assign trans_en     = transEn_q;
  assign tx_data      = txData_q;
  assign meta_ack     = metaAck_q;
  assign data_ack     = dataAck_q;
  assign readout_done = readoutDone_q;
  assign grant_meta   = grantMeta_q;
  assign busy_err     = busyErr_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: a behavioural UART drives tx_busy after each strobe,
// and a monitor logs every transmitted byte with its owner.
module tb_tx_arbiter;

  logic        clock;
  logic        reset;
  logic        meta_req;
  logic [7:0]  meta_byte;
  logic        meta_last;
  logic        meta_ack;
  logic        data_valid;
  logic [7:0]  data_byte;
  logic        data_ack;
  logic        start_readout;
  logic [15:0] read_count;
  logic        readout_done;
  logic        tx_busy;
  logic        trans_en;
  logic [7:0]  tx_data;
  logic        grant_meta;
  logic        busy_err;

  int nCompared = 0;
  int nMismatched = 0;

  int busyLen = 0;
  int uartCnt = 0;
  int transCnt = 0;
  int metaAckCnt = 0;
  int dataAckCnt = 0;
  int doneCnt = 0;
  int doneWithAck = 0;
  logic [7:0] logByte[$];
  logic       logMeta[$];

  tx_arbiter #(.SAMPLE_WIDTH(8), .BUSY_TIMEOUT(16)) dut (
    .clock(clock), .reset(reset),
    .meta_req(meta_req), .meta_byte(meta_byte), .meta_last(meta_last), .meta_ack(meta_ack),
    .data_valid(data_valid), .data_byte(data_byte), .data_ack(data_ack),
    .start_readout(start_readout), .read_count(read_count), .readout_done(readout_done),
    .tx_busy(tx_busy), .trans_en(trans_en), .tx_data(tx_data),
    .grant_meta(grant_meta), .busy_err(busy_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // UART model: busy for busyLen cycles after a strobe; busyLen 0 means it never responds.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clock);
      if (reset === 1'b1) begin
        uartCnt = 0;
        tx_busy = 1'b0;
      end else if (uartCnt > 0) begin
        uartCnt--;
        if (uartCnt == 0) tx_busy = 1'b0;
      end else if (trans_en === 1'b1 && busyLen > 0) begin
        tx_busy = 1'b1;
        uartCnt = busyLen;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (trans_en === 1'b1) begin
        transCnt++;
        logByte.push_back(tx_data);
        logMeta.push_back(grant_meta);
      end
      if (meta_ack === 1'b1) metaAckCnt++;
      if (data_ack === 1'b1) dataAckCnt++;
      if (readout_done === 1'b1) begin
        doneCnt++;
        if (data_ack === 1'b1) doneWithAck++;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    meta_req = 1'b0; meta_byte = 8'h00; meta_last = 1'b0;
    data_valid = 1'b0; data_byte = 8'h00;
    start_readout = 1'b0; read_count = 16'd0;
    tick(); tick();
    nCompared++;
    if ({trans_en, meta_ack, data_ack, readout_done, grant_meta, busy_err} !== 6'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_flags: got %b required 000000",
               {trans_en, meta_ack, data_ack, readout_done, grant_meta, busy_err});
    end
    nCompared++;
    if (tx_data !== 8'h00) begin
      nMismatched++;
      $display("[TB] FAIL reset_tx_data: got %h required 00", tx_data);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_meta();
    int t0, a0, k, holdBad;
    bit seen;
    busyLen = 10;
    t0 = transCnt; a0 = metaAckCnt; holdBad = 0; seen = 0; k = 0;
    meta_byte = 8'hA5; meta_last = 1'b1; meta_req = 1'b1;
    tick();
    nCompared++;
    if (trans_en !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL meta_latency1: trans_en got %b required 0", trans_en);
    end
    tick();
    nCompared++;
    if (trans_en !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL meta_latency2: trans_en got %b required 1", trans_en);
    end
    nCompared++;
    if (tx_data !== 8'hA5 || grant_meta !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL meta_issue: tx_data/grant got %h/%b required a5/1", tx_data, grant_meta);
    end
    while (!seen && k < 40) begin
      tick();
      k++;
      if (tx_data !== 8'hA5) holdBad++;
      if (meta_ack === 1'b1) seen = 1;
    end
    nCompared++;
    if (!seen || k != 11) begin
      nMismatched++;
      $display("[TB] FAIL meta_ack_timing: ack seen=%0d after %0d cycles, required 11", seen, k);
    end
    meta_req = 1'b0;
    tick();
    nCompared++;
    if (meta_ack !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL meta_ack_pulse: got %b required 0", meta_ack);
    end
    nCompared++;
    if (holdBad != 0) begin
      nMismatched++;
      $display("[TB] FAIL meta_hold: tx_data changed %0d times, required 0", holdBad);
    end
    repeat (5) tick();
    nCompared++;
    if (metaAckCnt - a0 != 1 || transCnt - t0 != 1) begin
      nMismatched++;
      $display("[TB] FAIL meta_counts: acks/strobes got %0d/%0d required 1/1",
               metaAckCnt - a0, transCnt - t0);
    end
  endtask

  task automatic test_burst();
    logic [7:0] tab [3];
    int t0, d0, r0, w0, idx, k, n;
    tab[0] = 8'h11; tab[1] = 8'h22; tab[2] = 8'h33;
    busyLen = 3;
    t0 = transCnt; d0 = dataAckCnt; r0 = doneCnt; w0 = doneWithAck; idx = 0; k = 0;
    start_readout = 1'b1; read_count = 16'd3; data_valid = 1'b1; data_byte = tab[0];
    tick();
    start_readout = 1'b0;
    while (idx < 3 && k < 200) begin
      tick();
      k++;
      if (data_ack === 1'b1) begin
        idx++;
        nCompared++;
        if (readout_done !== (idx == 3)) begin
          nMismatched++;
          $display("[TB] FAIL burst_done_ack%0d: readout_done got %b required %0d",
                   idx, readout_done, (idx == 3));
        end
        if (idx < 3) data_byte = tab[idx];
        else data_valid = 1'b0;
      end
    end
    repeat (4) tick();
    nCompared++;
    if (transCnt - t0 != 3 || dataAckCnt - d0 != 3 || doneCnt - r0 != 1 || doneWithAck - w0 != 1) begin
      nMismatched++;
      $display("[TB] FAIL burst_counts: strobes/acks/done/coincident got %0d/%0d/%0d/%0d required 3/3/1/1",
               transCnt - t0, dataAckCnt - d0, doneCnt - r0, doneWithAck - w0);
    end
    n = logByte.size();
    nCompared++;
    if (n < 3 || {logByte[n-3], logByte[n-2], logByte[n-1]} !== 24'h112233 ||
        {logMeta[n-3], logMeta[n-2], logMeta[n-1]} !== 3'b000) begin
      nMismatched++;
      $display("[TB] FAIL burst_bytes: got %h %h %h required 11 22 33 as data",
               (n >= 3) ? logByte[n-3] : 8'hxx, (n >= 2) ? logByte[n-2] : 8'hxx,
               (n >= 1) ? logByte[n-1] : 8'hxx);
    end
  endtask

  task automatic test_meta_priority();
    logic [55:0] gotBytes;
    logic [6:0]  gotMeta;
    int n0, midx, didx, k, lockBad, r0;
    busyLen = 2;
    midx = 0; didx = 0; k = 0; lockBad = 0; r0 = doneCnt;
    n0 = logByte.size();
    start_readout = 1'b1; read_count = 16'd2;
    tick();
    start_readout = 1'b0;
    data_valid = 1'b1; data_byte = 8'h44;
    meta_req = 1'b1; meta_byte = 8'hC1; meta_last = 1'b0;
    while (didx < 2 && k < 300) begin
      tick();
      k++;
      if (meta_ack !== 1'b1 && midx >= 1 && midx <= 4 && grant_meta !== 1'b1) lockBad++;
      if (meta_ack === 1'b1) begin
        midx++;
        if (midx == 5) meta_req = 1'b0;
        else begin
          meta_byte = 8'(8'hC1 + midx);
          meta_last = (midx == 4);
        end
      end
      if (data_ack === 1'b1) begin
        didx++;
        if (didx == 2) data_valid = 1'b0;
        else data_byte = 8'h45;
      end
    end
    repeat (3) tick();
    gotBytes = 'x; gotMeta = 'x;
    if (logByte.size() == n0 + 7) begin
      for (int i = 0; i < 7; i++) begin
        gotBytes[55 - 8*i -: 8] = logByte[n0 + i];
        gotMeta[6 - i] = logMeta[n0 + i];
      end
    end
    nCompared++;
    if (gotBytes !== 56'hC1C2C3C4C54445) begin
      nMismatched++;
      $display("[TB] FAIL prio_order: bytes got %h required c1c2c3c4c54445", gotBytes);
    end
    nCompared++;
    if (gotMeta !== 7'b1111100) begin
      nMismatched++;
      $display("[TB] FAIL prio_owner: owners got %b required 1111100", gotMeta);
    end
    nCompared++;
    if (lockBad != 0) begin
      nMismatched++;
      $display("[TB] FAIL prio_lock: grant_meta dropped %0d times mid-message, required 0", lockBad);
    end
    nCompared++;
    if (doneCnt - r0 != 1) begin
      nMismatched++;
      $display("[TB] FAIL prio_done: readout_done got %0d pulses required 1", doneCnt - r0);
    end
  endtask

  task automatic test_zero_count();
    int t0, d0, k;
    bit seen;
    busyLen = 2;
    t0 = transCnt; d0 = dataAckCnt;
    data_valid = 1'b1; data_byte = 8'h66;
    start_readout = 1'b1; read_count = 16'd0;
    tick();
    start_readout = 1'b0;
    nCompared++;
    if (readout_done !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL zero_done: readout_done got %b required 1", readout_done);
    end
    tick();
    nCompared++;
    if (readout_done !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL zero_done_pulse: readout_done got %b required 0", readout_done);
    end
    repeat (8) tick();
    nCompared++;
    if (transCnt != t0 || dataAckCnt != d0) begin
      nMismatched++;
      $display("[TB] FAIL zero_no_tx: strobes/acks got %0d/%0d required 0/0",
               transCnt - t0, dataAckCnt - d0);
    end
    start_readout = 1'b1; read_count = 16'd2;
    tick();
    start_readout = 1'b0;
    k = 0;
    while (trans_en !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    start_readout = 1'b1; read_count = 16'd5;
    tick();
    start_readout = 1'b0;
    seen = 0; k = 0;
    while (!seen && k < 100) begin
      tick();
      k++;
      if (readout_done === 1'b1) seen = 1;
    end
    repeat (10) tick();
    nCompared++;
    if (!seen || transCnt - t0 != 2 || dataAckCnt - d0 != 2) begin
      nMismatched++;
      $display("[TB] FAIL restart_ignored: done=%0d strobes/acks got %0d/%0d required 1 2/2",
               seen, transCnt - t0, dataAckCnt - d0);
    end
    data_valid = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int a0, k, j;
    bit seen;
    busyLen = 0;
    a0 = metaAckCnt; k = 0; j = 0; seen = 0;
    meta_req = 1'b1; meta_byte = 8'h5A; meta_last = 1'b1;
    while (trans_en !== 1'b1 && k < 10) begin
      tick();
      k++;
    end
    nCompared++;
    if (busy_err !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL timeout_pre: busy_err got %b required 0", busy_err);
    end
    while (!seen && j < 40) begin
      tick();
      j++;
      if (meta_ack === 1'b1) seen = 1;
    end
    nCompared++;
    if (!seen || j != 16 || busy_err !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL timeout_ack: ack=%0d after %0d cycles busy_err=%b required 1 after 16 busy_err=1",
               seen, j, busy_err);
    end
    meta_req = 1'b0;
    repeat (5) tick();
    nCompared++;
    if (busy_err !== 1'b1 || metaAckCnt - a0 != 1) begin
      nMismatched++;
      $display("[TB] FAIL timeout_sticky: busy_err/acks got %b/%0d required 1/1",
               busy_err, metaAckCnt - a0);
    end
  endtask

  task automatic test_back_to_back_reset();
    int a0, t0, k, n;
    bit seen;
    busyLen = 20;
    a0 = metaAckCnt; t0 = transCnt; k = 0;
    meta_req = 1'b1; meta_byte = 8'h77; meta_last = 1'b1;
    while (trans_en !== 1'b1 && k < 10) begin
      tick();
      k++;
    end
    repeat (5) tick();
    reset = 1'b1;
    meta_req = 1'b0;
    tick();
    nCompared++;
    if ({trans_en, meta_ack, data_ack, readout_done, grant_meta, busy_err} !== 6'b0 || tx_data !== 8'h00) begin
      nMismatched++;
      $display("[TB] FAIL midreset_outputs: flags %b tx_data %h required 000000 00",
               {trans_en, meta_ack, data_ack, readout_done, grant_meta, busy_err}, tx_data);
    end
    reset = 1'b0;
    repeat (25) tick();
    nCompared++;
    if (metaAckCnt != a0) begin
      nMismatched++;
      $display("[TB] FAIL midreset_no_ack: acks got %0d required 0", metaAckCnt - a0);
    end
    busyLen = 4;
    meta_req = 1'b1; meta_byte = 8'h3C; meta_last = 1'b1;
    seen = 0; k = 0;
    while (!seen && k < 60) begin
      tick();
      k++;
      if (meta_ack === 1'b1) seen = 1;
    end
    nCompared++;
    if (!seen || tx_data !== 8'h3C) begin
      nMismatched++;
      $display("[TB] FAIL midreset_new: ack=%0d tx_data %h required 1 3c", seen, tx_data);
    end
    meta_req = 1'b0;
    repeat (3) tick();
    n = logByte.size();
    nCompared++;
    if (metaAckCnt - a0 != 1 || transCnt - t0 != 2 || n < 1 || logByte[n-1] !== 8'h3C) begin
      nMismatched++;
      $display("[TB] FAIL midreset_counts: acks/strobes got %0d/%0d required 1/2",
               metaAckCnt - a0, transCnt - t0);
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_single_meta();
    test_burst();
    test_meta_priority();
    test_zero_count();
    test_timeout();
    test_back_to_back_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
